// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer. It drives one external 1-bit ALU slice LSB first
// and assembles a WIDTH-bit result. SLT/SLTU need a second pass so the
// computed less bit can be injected at bit 0 through the slice's less inputs.
module alu_bitserial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_c_o,
  output logic             slice_invert_o,
  output logic             slice_less_o,
  output logic             slice_lessu_o,
  output logic [3:0]       slice_op_o,
  input  logic             slice_res_i,
  input  logic             slice_c_i,
  input  logic             slice_set_i
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cin_msb_q, cin_msb_d;
  logic               cout_q, cout_d;
  logic               set_msb_q, set_msb_d;
  logic               err_q, err_d;

  logic               op_addsub;
  logic               op_cmp;
  logic               op_inv;
  logic               ovf;
  logic               less;
  logic               lessu;

  // Operation class decode and flags derived from the stored MSB slice state.
  always_comb begin
    op_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    op_cmp    = (op_q == OP_SLT) || (op_q == OP_SLTU);
    op_inv    = (op_q == OP_SUB) || op_cmp;
    ovf       = cin_msb_q ^ cout_q;
    less      = set_msb_q ^ ovf;
    lessu     = ~cout_q;
  end

  // State register and datapath flops; everything clears on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      cout_q    <= 1'b0;
      set_msb_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      cout_q    <= cout_d;
      set_msb_q <= set_msb_d;
      err_q     <= err_d;
    end
  end

  // Next-state, datapath update and slice drive for each sequencer phase.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    cnt_d          = cnt_q;
    carry_d        = carry_q;
    cin_msb_d      = cin_msb_q;
    cout_d         = cout_q;
    set_msb_d      = set_msb_q;
    err_d          = err_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    slice_a_o      = 1'b0;
    slice_b_o      = 1'b0;
    slice_c_o      = 1'b0;
    slice_invert_o = 1'b0;
    slice_less_o   = 1'b0;
    slice_lessu_o  = 1'b0;
    slice_op_o     = 4'b0000;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          a_d       = a_i;
          b_d       = b_i;
          op_d      = op_i;
          cnt_d     = '0;
          res_d     = '0;
          carry_d   = (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU);
          cin_msb_d = 1'b0;
          cout_d    = 1'b0;
          set_msb_d = 1'b0;
          err_d     = (op_i == OP_ILL);
          state_d   = (op_i == OP_ILL) ? RESP : PASS1;
        end
      end

      PASS1: begin
        slice_a_o      = a_q[0];
        slice_b_o      = b_q[0];
        slice_c_o      = carry_q;
        slice_invert_o = op_inv;
        case (op_q)
          OP_AND:  slice_op_o = 4'b0000;
          OP_OR:   slice_op_o = 4'b0001;
          OP_XOR:  slice_op_o = 4'b0100;
          default: slice_op_o = 4'b0010;
        endcase
        res_d   = {slice_res_i, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_c_i;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cin_msb_d = carry_q;
          cout_d    = slice_c_i;
          set_msb_d = slice_set_i;
          cnt_d     = '0;
          state_d   = op_cmp ? PASS2 : RESP;
        end
      end

      PASS2: begin
        slice_op_o = (op_q == OP_SLT) ? 4'b0011 : 4'b0101;
        if (cnt_q == '0) begin
          slice_less_o  = (op_q == OP_SLT) & less;
          slice_lessu_o = (op_q == OP_SLTU) & lessu;
        end
        res_d = {slice_res_i, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end

      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Result and flag outputs; carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    result_o   = res_q;
    carry_o    = op_addsub & cout_q;
    overflow_o = op_addsub & ovf;
    zero_o     = (state_q == RESP) && (res_q == '0);
    err_o      = err_q;
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Scoreboard bench for alu_bitserial_seq at WIDTH=8 with a behavioural 1-bit
// ALU slice attached to the slice port.
module tb_alu_bitserial_seq;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [2:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [W-1:0] result_o;
  logic         carry_o, overflow_o, zero_o, err_o;
  logic         slice_a_o, slice_b_o, slice_c_o, slice_invert_o;
  logic         slice_less_o, slice_lessu_o;
  logic [3:0]   slice_op_o;
  logic         slice_res_i, slice_c_i, slice_set_i;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .result_o      (result_o),
    .carry_o       (carry_o),
    .overflow_o    (overflow_o),
    .zero_o        (zero_o),
    .err_o         (err_o),
    .slice_a_o     (slice_a_o),
    .slice_b_o     (slice_b_o),
    .slice_c_o     (slice_c_o),
    .slice_invert_o(slice_invert_o),
    .slice_less_o  (slice_less_o),
    .slice_lessu_o (slice_lessu_o),
    .slice_op_o    (slice_op_o),
    .slice_res_i   (slice_res_i),
    .slice_c_i     (slice_c_i),
    .slice_set_i   (slice_set_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural 1-bit ALU slice (b optionally inverted, full adder, muxed result).
  logic sl_bb, sl_sum;
  always_comb begin
    sl_bb       = slice_b_o ^ slice_invert_o;
    sl_sum      = slice_a_o ^ sl_bb ^ slice_c_o;
    slice_c_i   = (slice_a_o & sl_bb) | (slice_a_o & slice_c_o) | (sl_bb & slice_c_o);
    slice_set_i = sl_sum;
    case (slice_op_o)
      4'b0000: slice_res_i = slice_a_o & sl_bb;
      4'b0001: slice_res_i = slice_a_o | sl_bb;
      4'b0010: slice_res_i = sl_sum;
      4'b0100: slice_res_i = slice_a_o ^ sl_bb;
      4'b0011: slice_res_i = slice_less_o;
      4'b0101: slice_res_i = slice_lessu_o;
      default: slice_res_i = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Slice activity counters, sampled mid-cycle.
  int n_inv = 0, n_op3 = 0, n_op5 = 0, n_lss = 0, n_lssu = 0, n_act = 0;
  always @(negedge clk_i) begin
    if (slice_invert_o) n_inv = n_inv + 1;
    if (slice_op_o == 4'b0011) n_op3 = n_op3 + 1;
    if (slice_op_o == 4'b0101) n_op5 = n_op5 + 1;
    if (slice_less_o) n_lss = n_lss + 1;
    if (slice_lessu_o) n_lssu = n_lssu + 1;
    if (slice_a_o | slice_b_o | slice_c_o | slice_invert_o | slice_less_o |
        slice_lessu_o | (slice_op_o != 4'b0000)) n_act = n_act + 1;
  end

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         c, v, z, e;
    int           lat, hold, acc;
    int           inv, op3, op5, lss, lssu, act;
    int           s_inv, s_op3, s_op5, s_lss, s_lssu, s_act;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input item_t it, input string tag);
    chk({it.name, tag, ".result"},   32'(result_o),   32'(it.res));
    chk({it.name, tag, ".carry"},    32'(carry_o),    32'(it.c));
    chk({it.name, tag, ".overflow"}, 32'(overflow_o), 32'(it.v));
    chk({it.name, tag, ".zero"},     32'(zero_o),     32'(it.z));
    chk({it.name, tag, ".err"},      32'(err_o),      32'(it.e));
    chk({it.name, tag, ".req_ready"},32'(req_ready_o),32'(0));
  endtask

  // Issue one request; expected response goes to the scoreboard when accepted.
  task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic c,
                       input logic v, input logic z, input logic e, input int lat,
                       input int hold, input bit push);
    item_t it;
    int t;
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1;
    t = 0;
    while (!req_ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (!req_ready_o) begin
      chk({name, ".accept_timeout"}, 32'(req_ready_o), 32'(1));
      req_valid_i = 1'b0;
      return;
    end
    it.name = name; it.res = res; it.c = c; it.v = v; it.z = z; it.e = e;
    it.lat = lat; it.hold = hold; it.acc = cyc + 1;
    it.inv  = (op == 3'd3 || op == 3'd5 || op == 3'd6) ? W : 0;
    it.op3  = (op == 3'd5) ? W : 0;
    it.op5  = (op == 3'd6) ? W : 0;
    it.lss  = (op == 3'd5) ? int'(res[0]) : 0;
    it.lssu = (op == 3'd6) ? int'(res[0]) : 0;
    it.act  = (op == 3'd7) ? 0 : -1;
    it.s_inv = n_inv; it.s_op3 = n_op3; it.s_op5 = n_op5;
    it.s_lss = n_lss; it.s_lssu = n_lssu; it.s_act = n_act;
    if (push) q.push_back(it);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    if (q.size() != 0) chk({name, ".drain_timeout"}, 32'(q.size()), 32'(0));
  endtask

  // Monitor: consumes responses, checks latency, stability and the handshake.
  initial begin
    item_t exp;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && rsp_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid_o), 32'(0));
        end else begin
          exp = q[0];
          chk({exp.name, ".latency"}, 32'(cyc - exp.acc + 1), 32'(exp.lat));
          chk_out(exp, "");
          chk({exp.name, ".n_invert"}, 32'(n_inv - exp.s_inv), 32'(exp.inv));
          chk({exp.name, ".n_op0011"}, 32'(n_op3 - exp.s_op3), 32'(exp.op3));
          chk({exp.name, ".n_op0101"}, 32'(n_op5 - exp.s_op5), 32'(exp.op5));
          chk({exp.name, ".n_less"},   32'(n_lss - exp.s_lss), 32'(exp.lss));
          chk({exp.name, ".n_lessu"},  32'(n_lssu - exp.s_lssu), 32'(exp.lssu));
          if (exp.act >= 0) chk({exp.name, ".n_active"}, 32'(n_act - exp.s_act), 32'(exp.act));
          for (int h = 0; h < exp.hold; h++) begin
            @(negedge clk_i);
            chk({exp.name, ".hold_valid"}, 32'(rsp_valid_o), 32'(1));
            chk_out(exp, ".hold");
          end
          rsp_ready_i = 1'b1;
          @(negedge clk_i);
          rsp_ready_i = 1'b0;
          chk({exp.name, ".post_valid"}, 32'(rsp_valid_o), 32'(0));
          chk({exp.name, ".post_ready"}, 32'(req_ready_o), 32'(1));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset.req_ready", 32'(req_ready_o), 32'(1));
    chk("reset.rsp_valid", 32'(rsp_valid_o), 32'(0));
    chk("reset.outputs", 32'({result_o, carry_o, overflow_o, zero_o, err_o}), 32'(0));
    chk("reset.slice", 32'({slice_a_o, slice_b_o, slice_c_o, slice_invert_o,
                             slice_less_o, slice_lessu_o, slice_op_o}), 32'(0));
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    //    name      op    a      b      result c     v     z     e     lat hold push
    issue("add7f",  3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 9,  0, 1);
    issue("sub05",  3'd3, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9,  0, 1);
    issue("sltff",  3'd5, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 17, 0, 1);
    issue("sltuff", 3'd6, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 17, 0, 1);
    issue("slt80",  3'd5, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 17, 0, 1);
    issue("slt7f",  3'd5, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 17, 0, 1);
    issue("addhold",3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9,  5, 1);
    issue("illegal",3'd7, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1,  0, 1);
    issue("and",    3'd0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, 9,  0, 1);
    issue("or",     3'd1, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0, 1'b0, 1'b0, 9,  0, 1);
    issue("xor",    3'd4, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 9,  0, 1);
    issue("sltu01", 3'd6, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 17, 0, 1);
    issue("sub00",  3'd3, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9,  0, 1);
    issue("sub80",  3'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 9,  0, 1);
    wait_drain("main");

    // Abort an AND mid-way through the first pass; no response may appear.
    issue("abort",  3'd0, 8'hA5, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 9,  0, 0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("abort.rsp_valid", 32'(rsp_valid_o), 32'(0));
    chk("abort.outputs", 32'({result_o, carry_o, overflow_o, zero_o, err_o}), 32'(0));
    chk("abort.slice", 32'({slice_a_o, slice_b_o, slice_c_o, slice_invert_o,
                             slice_less_o, slice_lessu_o, slice_op_o}), 32'(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("abort.req_ready", 32'(req_ready_o), 32'(1));
    issue("after",  3'd0, 8'hF0, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 9,  0, 1);
    wait_drain("final");
    repeat (3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_bitserial_seq.md
Name: alu_bitserial_seq

Overview:
- Sequencer that drives one external 1-bit ALU slice (ALUbitN) serially, LSB first, to compute a WIDTH-bit result.
- Owns the operand and result shift registers, the carry flip-flop, the slice opcode/invert selection and the SLT/SLTU less computation.
- Sits between the decode stage (valid/ready request) and the register write-back (valid/ready response).
- Lets the datapath share a single slice instead of instantiating WIDTH slices.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  sequencer can accept a request.
- op_i  input  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLT, 6 SLTU, 7 illegal.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  consumer accepts response.
- result_o  output  WIDTH  result word.
- carry_o  output  1  final carry-out (ADD/SUB only, else 0).
- overflow_o  output  1  signed overflow (ADD/SUB only, else 0).
- zero_o  output  1  result_o == 0.
- err_o  output  1  illegal opcode.
- slice_a_o, slice_b_o, slice_c_o  output  1 each  slice a_i, b_i, c_i.
- slice_invert_o  output  1  slice invert_i.
- slice_less_o, slice_lessu_o  output  1 each  slice less_i, lessu_i.
- slice_op_o  output  4  slice operacion_i.
- slice_res_i, slice_c_i, slice_set_i  input  1 each  slice resultado_o, c_o, set_o.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - All registers clear.
  - req_ready_o=1 after reset; all other outputs 0.
- States: IDLE, PASS1, PASS2, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On req_valid_i, latch a_i, b_i and op_i; clear the counter.
  - Carry_q is set to 1 for SUB/SLT/SLTU and 0 otherwise.
  - Legal op → PASS1. Illegal op → RESP with result 0, err_o=1, no slice activity.
- PASS1 (WIDTH cycles, counter 0..WIDTH-1):
  - Drive slice_a_o=a_q[0], slice_b_o=b_q[0], slice_c_o=carry_q.
  - slice_invert_o=1 for SUB/SLT/SLTU.
  - slice_op_o: AND→0000, OR→0001, ADD/SUB/SLT/SLTU→0010, XOR→0100.
  - Each cycle: shift slice_res_i into res_q MSB (res_q shifts right); a_q and b_q shift right; carry_q<=slice_c_i.
  - At counter WIDTH-1: cin_msb<=carry_q, cout<=slice_c_i, set_msb<=slice_set_i.
  - Exit to PASS2 for SLT/SLTU, otherwise to RESP.
- Flags, computed at the end of PASS1:
  - overflow = cin_msb ^ cout.
  - less = set_msb ^ overflow.
  - lessu = ~cout.
- PASS2 (SLT/SLTU only, WIDTH cycles):
  - slice_op_o=0011 for SLT or 0101 for SLTU.
  - slice_less_o (SLT) or slice_lessu_o (SLTU) = computed value at counter 0, 0 at all other counts.
  - slice_a_o, slice_b_o, slice_c_o = 0.
  - res_q is rebuilt from slice_res_i the same way as in PASS1.
- Slice drive outside PASS1/PASS2: all slice outputs 0.
- Latency, accept edge to rsp_valid_o high:
  - WIDTH+1 cycles for logic/arithmetic ops.
  - 2·WIDTH+1 cycles for SLT/SLTU.
  - 1 cycle for an illegal op.
- RESP:
  - rsp_valid_o=1; result_o=res_q and flags are stable.
  - Hold until rsp_ready_i; on the handshake → IDLE.
  - No new request is accepted in the same cycle as the handshake.
- carry_o/overflow_o are forced 0 for AND/OR/XOR/SLT/SLTU.
- zero_o is valid for all ops.
- req_valid_i while busy is ignored; the requester must hold it.
- Reset asserted in PASS1/PASS2/RESP aborts the operation; no response is produced.
- Counter wraps only via the state transitions; it is never compared beyond WIDTH-1.

Test Plan (WIDTH=8, external ALUbitN instance):
- ADD a=0x7F b=0x01 → result 0x80, overflow=1, carry=0, zero=0, rsp_valid 9 cycles after accept.
- SUB a=0x05 b=0x05 → result 0x00, zero=1, carry=1, overflow=0; slice_invert_o=1 for all 8 PASS1 cycles.
- SLT a=0xFF b=0x01 → 0x01; SLTU same operands → 0x00; each responds at 17 cycles; slice_op_o=0011/0101 during PASS2.
- SLT a=0x80 b=0x7F (overflow case) → 0x01; SLT a=0x7F b=0x80 → 0x00.
- Hold rsp_ready_i=0 for 5 cycles after rsp_valid_o → result/flags stable, req_ready_o=0; single-cycle rsp_ready_i → IDLE next cycle.
- op_i=7 → rsp 1 cycle later, err_o=1, result 0.
- Assert rst_n_i mid-PASS1 of an AND → all outputs 0 immediately, req_ready_o=1 after release, next request correct.
